kf6845_light_pen_strobe: RTL and testbench

KF6845_LIGHT_PEN_STROBE -- requirements
Module: KF6845_Light_Pen_Strobe

---
 rtl/kf6845_light_pen_strobe.sv | 168 ++++++++++++++++
 tb/tb_kf6845_light_pen_strobe.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/kf6845_light_pen_strobe.sv
// Light pen emulator for a KF6845-style CRTC.
// Watches the refresh address stream for a chosen MA, waits a programmable
// photodetector latency, then drives a registered LPSTB pulse into the CRTC.
// A capture waits for the start of a fresh frame, searches for up to
// TIMEOUT_FRAMES frames, and reports either done (strobe issued) or timeout.

module kf6845_light_pen_strobe #(
   parameter int unsigned LATENCY        = 2,  // 0..15 character clocks
   parameter int unsigned TIMEOUT_FRAMES = 4   // 1..255 frames
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        video_clock_enable,
   input  logic [13:0] MA,
   input  logic        DE,
   input  logic        VSYNC,
   input  logic        arm,
   input  logic        abort,
   input  logic [13:0] target_address,
   input  logic [3:0]  pulse_width,
   output logic        busy,
   output logic        LPSTB,
   output logic        done,
   output logic        timeout,
   output logic [13:0] hit_address
);

   localparam logic [3:0] LP_LATENCY = LATENCY[3:0];
   localparam logic [7:0] LP_TIMEOUT = TIMEOUT_FRAMES[7:0];

   typedef enum logic [2:0] {
      IDLE,
      WAIT_FRAME,
      SEARCH,
      DELAY,
      STROBE
   } state_t;

   state_t      r_state;
   logic        r_vsync_q;
   logic [13:0] r_target;
   logic [3:0]  r_width;
   logic [7:0]  r_frame_cnt;
   logic [3:0]  r_delay_cnt;
   logic [3:0]  r_width_cnt;
   logic        r_busy;
   logic        r_lpstb;
   logic        r_done;
   logic        r_timeout;
   logic [13:0] r_hit;

   logic        w_vsync_rise;
   logic        w_match;
   logic [7:0]  w_frame_next;
   logic [3:0]  w_strobe_len;

   assign w_vsync_rise = video_clock_enable & VSYNC & ~r_vsync_q;
   assign w_match      = video_clock_enable & DE & (MA == r_target);
   assign w_frame_next = r_frame_cnt + 8'd1;
   assign w_strobe_len = (r_width == 4'd0) ? 4'd1 : r_width;

   // VSYNC history for edge detection; resets high so no edge on the first enabled cycle
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_vsync_q <= 1'b1;
      end else if (video_clock_enable) begin
         r_vsync_q <= VSYNC;
      end
   end

   // Capture FSM with registered status outputs; abort overrides every transition
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_target    <= '0;
         r_width     <= 4'd1;
         r_frame_cnt <= '0;
         r_delay_cnt <= '0;
         r_width_cnt <= '0;
         r_busy      <= 1'b0;
         r_lpstb     <= 1'b0;
         r_done      <= 1'b0;
         r_timeout   <= 1'b0;
         r_hit       <= '0;
      end else begin
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
         if (abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_lpstb <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (arm) begin
                     r_target <= target_address;
                     r_width  <= pulse_width;
                     r_state  <= WAIT_FRAME;
                     r_busy   <= 1'b1;
                  end
               end
               WAIT_FRAME: begin
                  if (w_vsync_rise) begin
                     r_state     <= SEARCH;
                     r_frame_cnt <= '0;
                  end
               end
               SEARCH: begin
                  // a match on the same cycle as a VSYNC edge takes precedence
                  if (w_match) begin
                     r_hit <= MA;
                     if (LATENCY != 0) begin
                        r_state     <= DELAY;
                        r_delay_cnt <= LP_LATENCY;
                     end else begin
                        r_state     <= STROBE;
                        r_lpstb     <= 1'b1;
                        r_width_cnt <= w_strobe_len;
                     end
                  end else if (w_vsync_rise) begin
                     r_frame_cnt <= w_frame_next;
                     if (w_frame_next == LP_TIMEOUT) begin
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                     end
                  end
               end
               DELAY: begin
                  if (video_clock_enable) begin
                     if (r_delay_cnt <= 4'd1) begin
                        r_state     <= STROBE;
                        r_lpstb     <= 1'b1;
                        r_width_cnt <= w_strobe_len;
                     end else begin
                        r_delay_cnt <= r_delay_cnt - 4'd1;
                     end
                  end
               end
               STROBE: begin
                  if (video_clock_enable) begin
                     if (r_width_cnt <= 4'd1) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_lpstb <= 1'b0;
                        r_done  <= 1'b1;
                     end else begin
                        r_width_cnt <= r_width_cnt - 4'd1;
                     end
                  end
               end
               default: begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_lpstb <= 1'b0;
               end
            endcase
         end
      end
   end

   assign busy        = r_busy;
   assign LPSTB       = r_lpstb;
   assign done        = r_done;
   assign timeout     = r_timeout;
   assign hit_address = r_hit;

endmodule

// File: tb/tb_kf6845_light_pen_strobe.sv
// Bench for kf6845_light_pen_strobe: a LATENCY=2 instance and a LATENCY=0
// instance share all inputs; each vector names which one it checks.
// Expected outputs are queued as each vector is driven and compared after
// the following rising edge.

module tb_kf6845_light_pen_strobe;

   typedef struct packed {
      logic        rn, ce, ar, ab, de, vs;
      logic [13:0] ma, tgt;
      logic [3:0]  pw;
      logic        sel, bz, lp, dn, to, chk;
      logic [13:0] hit;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        video_clock_enable = 1'b1;
   logic [13:0] MA = '0;
   logic        DE = 1'b0;
   logic        VSYNC = 1'b0;
   logic        arm = 1'b0;
   logic        abort = 1'b0;
   logic [13:0] target_address = '0;
   logic [3:0]  pulse_width = '0;

   logic        busy, LPSTB, done, timeout;
   logic [13:0] hit_address;
   logic        busy_l0, lpstb_l0, done_l0, timeout_l0;
   logic [13:0] hit_l0;

   int n_checks = 0;
   int n_fail   = 0;

   vec_t  exp_q[$];
   string name_q[$];
   vec_t  tbl[$];

   always #5 clock = ~clock;

   kf6845_light_pen_strobe #(.LATENCY(2), .TIMEOUT_FRAMES(4)) dut (
      .clock(clock), .reset(reset), .video_clock_enable(video_clock_enable),
      .MA(MA), .DE(DE), .VSYNC(VSYNC), .arm(arm), .abort(abort),
      .target_address(target_address), .pulse_width(pulse_width),
      .busy(busy), .LPSTB(LPSTB), .done(done), .timeout(timeout),
      .hit_address(hit_address)
   );

   kf6845_light_pen_strobe #(.LATENCY(0), .TIMEOUT_FRAMES(4)) dut_l0 (
      .clock(clock), .reset(reset), .video_clock_enable(video_clock_enable),
      .MA(MA), .DE(DE), .VSYNC(VSYNC), .arm(arm), .abort(abort),
      .target_address(target_address), .pulse_width(pulse_width),
      .busy(busy_l0), .LPSTB(lpstb_l0), .done(done_l0), .timeout(timeout_l0),
      .hit_address(hit_l0)
   );

   function automatic vec_t V(input logic rn, ce, ar, ab, de, vs,
                              input logic [13:0] ma, tgt, input logic [3:0] pw,
                              input logic sel, bz, lp, dn, to, chk,
                              input logic [13:0] hit);
      vec_t v;
      v.rn = rn; v.ce = ce; v.ar = ar; v.ab = ab; v.de = de; v.vs = vs;
      v.ma = ma; v.tgt = tgt; v.pw = pw;
      v.sel = sel; v.bz = bz; v.lp = lp; v.dn = dn; v.to = to; v.chk = chk;
      v.hit = hit;
      return v;
   endfunction

   task automatic drive(input vec_t v, input string nm);
      @(negedge clock);
      reset = v.rn; video_clock_enable = v.ce; arm = v.ar; abort = v.ab;
      DE = v.de; VSYNC = v.vs; MA = v.ma; target_address = v.tgt;
      pulse_width = v.pw;
      exp_q.push_back(v);
      name_q.push_back(nm);
   endtask

   // Scoreboard: compare the oldest expectation just after each rising edge
   vec_t        e;
   string       enm;
   logic        a_bz, a_lp, a_dn, a_to;
   logic [13:0] a_hit;
   always @(posedge clock) begin
      #1;
      if (exp_q.size() != 0) begin
         e   = exp_q.pop_front();
         enm = name_q.pop_front();
         a_bz  = e.sel ? busy_l0    : busy;
         a_lp  = e.sel ? lpstb_l0   : LPSTB;
         a_dn  = e.sel ? done_l0    : done;
         a_to  = e.sel ? timeout_l0 : timeout;
         a_hit = e.sel ? hit_l0     : hit_address;
         n_checks++;
         if (a_bz !== e.bz || a_lp !== e.lp || a_dn !== e.dn || a_to !== e.to ||
             (e.chk && a_hit !== e.hit)) begin
            n_fail++;
            $display("FAIL %s: busy/lpstb/done/timeout/hit got %b%b%b%b/%h, expected %b%b%b%b/%h%s",
                     enm, a_bz, a_lp, a_dn, a_to, a_hit, e.bz, e.lp, e.dn, e.to, e.hit,
                     e.chk ? "" : " (hit not checked)");
         end
      end
   end

   initial begin
      // Columns: rn ce ar ab de vs ma tgt pw | sel busy lp done to chk hit
      // Reset, then basic hit: target 0x0123, width 3, with ce gaps in DELAY and STROBE
      tbl.push_back(V(0,1,0,0,0,0,14'h0000,14'h0000,0, 0,0,0,0,0,1,14'h0000));
      tbl.push_back(V(0,1,0,0,0,0,14'h0000,14'h0000,0, 0,0,0,0,0,1,14'h0000));
      tbl.push_back(V(1,1,0,0,0,0,14'h0000,14'h0000,0, 0,0,0,0,0,1,14'h0000));
      tbl.push_back(V(1,1,1,0,0,0,14'h0000,14'h0123,3, 0,1,0,0,0,0,14'h0000));
      tbl.push_back(V(1,1,0,0,0,0,14'h0000,14'h0000,0, 0,1,0,0,0,0,14'h0000));
      tbl.push_back(V(1,1,0,0,0,1,14'h0000,14'h0000,0, 0,1,0,0,0,0,14'h0000));
      tbl.push_back(V(1,1,0,0,0,1,14'h0123,14'h0000,0, 0,1,0,0,0,1,14'h0000));
      tbl.push_back(V(1,1,0,0,1,0,14'h0122,14'h0000,0, 0,1,0,0,0,1,14'h0000));
      tbl.push_back(V(1,1,0,0,1,0,14'h0123,14'h0000,0, 0,1,0,0,0,1,14'h0123));
      tbl.push_back(V(1,1,0,0,0,0,14'h0000,14'h0000,0, 0,1,0,0,0,0,14'h0000));
      tbl.push_back(V(1,0,0,0,0,0,14'h0000,14'h0000,0, 0,1,0,0,0,0,14'h0000));
      tbl.push_back(V(1,1,0,0,0,0,14'h0000,14'h0000,0, 0,1,1,0,0,0,14'h0000));
      tbl.push_back(V(1,1,0,0,0,0,14'h0000,14'h0000,0, 0,1,1,0,0,0,14'h0000));
      tbl.push_back(V(1,0,0,0,0,0,14'h0000,14'h0000,0, 0,1,1,0,0,0,14'h0000));
      tbl.push_back(V(1,1,0,0,0,0,14'h0000,14'h0000,0, 0,1,1,0,0,0,14'h0000));
      tbl.push_back(V(1,1,0,0,0,0,14'h0000,14'h0000,0, 0,0,0,1,0,1,14'h0123));
      tbl.push_back(V(1,1,0,0,0,0,14'h0000,14'h0000,0, 0,0,0,0,0,1,14'h0123));
      // DE gating, then match coinciding with a VSYNC edge (target 0x1555, width 2)
      tbl.push_back(V(1,1,1,0,0,0,14'h0000,14'h1555,2, 0,1,0,0,0,0,14'h0000));
      tbl.push_back(V(1,1,0,0,0,0,14'h0000,14'h0000,0, 0,1,0,0,0,0,14'h0000));
      tbl.push_back(V(1,1,0,0,0,1,14'h0000,14'h0000,0, 0,1,0,0,0,0,14'h0000));
      tbl.push_back(V(1,1,0,0,0,0,14'h1555,14'h0000,0, 0,1,0,0,0,1,14'h0123));
      tbl.push_back(V(1,1,0,0,1,1,14'h1555,14'h0000,0, 0,1,0,0,0,1,14'h1555));
      tbl.push_back(V(1,1,0,0,0,1,14'h0000,14'h0000,0, 0,1,0,0,0,0,14'h0000));
      tbl.push_back(V(1,1,0,0,0,1,14'h0000,14'h0000,0, 0,1,1,0,0,0,14'h0000));
      tbl.push_back(V(1,1,0,0,0,0,14'h0000,14'h0000,0, 0,1,1,0,0,0,14'h0000));
      tbl.push_back(V(1,1,0,0,0,0,14'h0000,14'h0000,0, 0,0,0,1,0,1,14'h1555));

      for (int i = 0; i < tbl.size(); i++)
         drive(tbl[i], $sformatf("tbl%0d", i));

      // Timeout: target never presented; expires on the 4th frame edge after WAIT_FRAME exits
      drive(V(1,1,1,0,0,0,14'h0000,14'h2AAA,1, 0,1,0,0,0,0,14'h0000), "to_arm");
      for (int f = 0; f <= 4; f++) begin
         for (int k = 0; k < 3; k++)
            drive(V(1,1,0,0,1,0,14'(256 + f*4 + k),14'h0000,0, 0,1,0,0,0,0,14'h0000),
                  $sformatf("to_line%0d_%0d", f, k));
         drive(V(1,1,0,0,1,1,14'(512 + f),14'h0000,0,
                 0,(f == 4) ? 1'b0 : 1'b1,0,0,(f == 4) ? 1'b1 : 1'b0,1,14'h1555),
               $sformatf("to_edge%0d", f));
      end
      drive(V(1,1,0,0,0,0,14'h0000,14'h0000,0, 0,0,0,0,0,1,14'h1555), "to_after");

      // Abort during DELAY, then arms while busy (0x3FFF) must be ignored
      drive(V(1,1,1,0,0,0,14'h0000,14'h0456,1, 0,1,0,0,0,0,14'h0000), "ab_arm");
      drive(V(1,1,0,0,0,0,14'h0000,14'h0000,0, 0,1,0,0,0,0,14'h0000), "ab_v0");
      drive(V(1,1,0,0,0,1,14'h0000,14'h0000,0, 0,1,0,0,0,0,14'h0000), "ab_v1");
      drive(V(1,1,0,0,1,0,14'h0456,14'h0000,0, 0,1,0,0,0,1,14'h0456), "ab_match");
      drive(V(1,1,0,1,0,0,14'h0000,14'h0000,0, 0,0,0,0,0,0,14'h0000), "ab_abort");
      drive(V(1,1,0,0,0,0,14'h0000,14'h0000,0, 0,0,0,0,0,0,14'h0000), "ab_idle1");
      drive(V(1,1,0,0,0,0,14'h0000,14'h0000,0, 0,0,0,0,0,1,14'h0456), "ab_idle2");
      drive(V(1,1,1,0,0,0,14'h0000,14'h0789,2, 0,1,0,0,0,0,14'h0000), "ra_arm");
      drive(V(1,1,1,0,0,0,14'h0000,14'h3FFF,5, 0,1,0,0,0,0,14'h0000), "ra_ign1");
      drive(V(1,1,1,0,0,1,14'h0000,14'h3FFF,5, 0,1,0,0,0,0,14'h0000), "ra_ign2");
      drive(V(1,1,1,0,1,0,14'h3FFF,14'h3FFF,5, 0,1,0,0,0,1,14'h0456), "ra_nomatch");
      drive(V(1,1,0,0,1,0,14'h0789,14'h0000,0, 0,1,0,0,0,1,14'h0789), "ra_match");
      drive(V(1,1,0,0,0,0,14'h0000,14'h0000,0, 0,1,0,0,0,0,14'h0000), "ra_d1");
      drive(V(1,1,0,0,0,0,14'h0000,14'h0000,0, 0,1,1,0,0,0,14'h0000), "ra_s1");
      drive(V(1,1,0,0,0,0,14'h0000,14'h0000,0, 0,1,1,0,0,0,14'h0000), "ra_s2");
      drive(V(1,1,0,0,0,0,14'h0000,14'h0000,0, 0,0,0,1,0,1,14'h0789), "ra_done");

      // LATENCY=0 instance, width 0: one-cycle strobe starting right after the match
      drive(V(0,1,0,0,0,0,14'h0000,14'h0000,0, 1,0,0,0,0,1,14'h0000), "l0_reset");
      drive(V(1,1,1,0,0,0,14'h0000,14'h0ABC,0, 1,1,0,0,0,0,14'h0000), "l0_arm");
      drive(V(1,1,0,0,0,0,14'h0000,14'h0000,0, 1,1,0,0,0,0,14'h0000), "l0_v0");
      drive(V(1,1,0,0,0,1,14'h0000,14'h0000,0, 1,1,0,0,0,0,14'h0000), "l0_v1");
      drive(V(1,1,0,0,1,0,14'h0ABC,14'h0000,0, 1,1,1,0,0,1,14'h0ABC), "l0_match");
      drive(V(1,1,0,0,0,0,14'h0000,14'h0000,0, 1,0,0,1,0,1,14'h0ABC), "l0_done");
      drive(V(1,1,0,0,0,0,14'h0000,14'h0000,0, 1,0,0,0,0,0,14'h0000), "l0_post");
      // the LATENCY=2 instance finishes its own width-0 strobe here
      drive(V(1,1,0,0,0,0,14'h0000,14'h0000,0, 0,0,0,1,0,1,14'h0ABC), "l2_w0_done");

      // Reset during STROBE, then re-arm on a ce=0 cycle with VSYNC already high
      drive(V(1,1,1,0,0,0,14'h0000,14'h0321,4, 0,1,0,0,0,0,14'h0000), "rs_arm");
      drive(V(1,1,0,0,0,0,14'h0000,14'h0000,0, 0,1,0,0,0,0,14'h0000), "rs_v0");
      drive(V(1,1,0,0,0,1,14'h0000,14'h0000,0, 0,1,0,0,0,0,14'h0000), "rs_v1");
      drive(V(1,1,0,0,1,0,14'h0321,14'h0000,0, 0,1,0,0,0,1,14'h0321), "rs_match");
      drive(V(1,1,0,0,0,0,14'h0000,14'h0000,0, 0,1,0,0,0,0,14'h0000), "rs_d1");
      drive(V(1,1,0,0,0,0,14'h0000,14'h0000,0, 0,1,1,0,0,0,14'h0000), "rs_s1");
      drive(V(1,1,0,0,0,0,14'h0000,14'h0000,0, 0,1,1,0,0,0,14'h0000), "rs_s2");
      drive(V(0,1,0,0,0,1,14'h0000,14'h0000,0, 0,0,0,0,0,1,14'h0000), "rs_reset");
      drive(V(1,0,1,0,0,1,14'h0000,14'h0001,1, 0,1,0,0,0,1,14'h0000), "rs_rearm");
      drive(V(1,1,0,0,1,1,14'h0001,14'h0000,0, 0,1,0,0,0,1,14'h0000), "rs_noedge1");
      drive(V(1,1,0,0,1,1,14'h0001,14'h0000,0, 0,1,0,0,0,1,14'h0000), "rs_noedge2");
      drive(V(1,1,0,0,0,0,14'h0000,14'h0000,0, 0,1,0,0,0,0,14'h0000), "rs_v0b");
      drive(V(1,1,0,0,0,1,14'h0000,14'h0000,0, 0,1,0,0,0,0,14'h0000), "rs_v1b");
      drive(V(1,1,0,0,1,0,14'h0001,14'h0000,0, 0,1,0,0,0,1,14'h0001), "rs_match2");
      drive(V(1,1,0,0,0,0,14'h0000,14'h0000,0, 0,1,0,0,0,0,14'h0000), "rs_d1b");
      drive(V(1,1,0,0,0,0,14'h0000,14'h0000,0, 0,1,1,0,0,0,14'h0000), "rs_s1b");
      drive(V(1,1,0,0,0,0,14'h0000,14'h0000,0, 0,0,0,1,0,1,14'h0001), "rs_done");

      @(negedge clock);
      @(negedge clock);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
